bus_rr_arbiter: RTL

- Parametrised N-client arbiter between the fetcher, data-cache and other bus masters and the single top-level memory bus.
- Grants the bus to one client per transaction using round-robin priority, and forwards that client's request burst with a per-client reqack.
- Routes the response beats back to the owning client only, then releases the bus.
- Adds ownership locking, fair arbitration, per-client acknowledgement and beat counting.

---
 rtl/bus_arb_pkg.sv | 27 ++
 rtl/rr_picker.sv | 35 +++
 rtl/bus_rr_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the round-robin bus arbiter.
//   arb_state_t : transaction phase (IDLE, REQ, RESP)
//   DEF_*       : default parameter values for the arbiter
//   onehot_of   : decodes a client index into a one-hot select vector
package bus_arb_pkg;

    localparam int unsigned MAX_CLIENTS       = 8;
    localparam int unsigned DEF_NUM_CLIENTS   = 2;
    localparam int unsigned DEF_DATA_WIDTH    = 64;
    localparam int unsigned DEF_TAG_WIDTH     = 13;
    localparam int unsigned DEF_RESP_BEATS    = 8;
    localparam int unsigned DEF_WRITE_TAG_BIT = 12;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    function automatic logic [MAX_CLIENTS-1:0] onehot_of(input logic [2:0] idx);
        logic [MAX_CLIENTS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin requester selection (purely combinational).
//   reqcyc     : per-client request valid
//   last_grant : client granted most recently
//   found      : at least one client is requesting
//   idx        : first requester scanning upward from last_grant+1, wrapping
module rr_picker #(
    parameter int unsigned N = 2,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] reqcyc,
    input  logic [W-1:0] last_grant,
    output logic         found,
    output logic [W-1:0] idx
);

    // Two passes: clients above last_grant first, then the wrapped-around
    // lower half. The second pass only fires if the first found nothing.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && reqcyc[i] && (i > 32'(last_grant))) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && reqcyc[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// N-client round-robin arbiter onto a single memory bus.
//   clk, reset           : clock, synchronous active-high reset
//   bus_req*/bus_reqack  : request channel towards the top-level bus
//   bus_resp*/bus_respack: response channel from the top-level bus
//   cl_req*/cl_reqack    : per-client request channels (client i at slice i)
//   cl_resp*/cl_respack  : per-client response channels
//   owner                : current/last grant (debug)
//   busy                 : a transaction is in progress
//   spurious_resp        : bus response beat seen outside the response phase
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = DEF_NUM_CLIENTS,
    parameter int unsigned BUS_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUS_TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int unsigned RESP_BEATS     = DEF_RESP_BEATS,
    parameter int unsigned WRITE_TAG_BIT  = DEF_WRITE_TAG_BIT
) (
    input  logic                                   clk,
    input  logic                                   reset,
    output logic [BUS_DATA_WIDTH-1:0]              bus_req,
    output logic                                   bus_reqcyc,
    output logic [BUS_TAG_WIDTH-1:0]               bus_reqtag,
    input  logic                                   bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0]              bus_resp,
    input  logic                                   bus_respcyc,
    input  logic [BUS_TAG_WIDTH-1:0]               bus_resptag,
    output logic                                   bus_respack,
    input  logic [NUM_CLIENTS*BUS_DATA_WIDTH-1:0]  cl_req,
    input  logic [NUM_CLIENTS-1:0]                 cl_reqcyc,
    input  logic [NUM_CLIENTS*BUS_TAG_WIDTH-1:0]   cl_reqtag,
    output logic [NUM_CLIENTS-1:0]                 cl_reqack,
    output logic [NUM_CLIENTS*BUS_DATA_WIDTH-1:0]  cl_resp,
    output logic [NUM_CLIENTS-1:0]                 cl_respcyc,
    output logic [NUM_CLIENTS*BUS_TAG_WIDTH-1:0]   cl_resptag,
    input  logic [NUM_CLIENTS-1:0]                 cl_respack,
    output logic [$clog2(NUM_CLIENTS)-1:0]         owner,
    output logic                                   busy,
    output logic                                   spurious_resp
);

    localparam int unsigned OW    = $clog2(NUM_CLIENTS);
    localparam int unsigned CNT_W = $clog2(RESP_BEATS + 1);

    arb_state_t       state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    last_grant_q, last_grant_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             wr_flag_q, wr_flag_d;

    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic [MAX_CLIENTS-1:0] owner_oh;

    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic                      own_reqcyc;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;

    rr_picker #(
        .N(NUM_CLIENTS),
        .W(OW)
    ) u_picker (
        .reqcyc    (cl_reqcyc),
        .last_grant(last_grant_q),
        .found     (pick_found),
        .idx       (pick_idx)
    );

    assign owner_oh = onehot_of(3'(owner_q));

    generate
        if (NUM_CLIENTS < MAX_CLIENTS) begin : g_oh_hi
            logic unused_oh_hi;
            assign unused_oh_hi = |owner_oh[MAX_CLIENTS-1:NUM_CLIENTS];
        end
    endgenerate

    // Owner's request/ack signals, AND-OR muxed on the registered owner.
    always_comb begin
        own_req     = '0;
        own_reqcyc  = 1'b0;
        own_reqtag  = '0;
        own_respack = 1'b0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            if (owner_oh[i]) begin
                own_req     = cl_req[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                own_reqcyc  = cl_reqcyc[i];
                own_reqtag  = cl_reqtag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH];
                own_respack = cl_respack[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        wr_flag_d    = wr_flag_q;

        bus_req     = '0;
        bus_reqcyc  = 1'b0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        cl_reqack   = '0;
        cl_resp     = '0;
        cl_respcyc  = '0;
        cl_resptag  = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d      = pick_idx;
                    last_grant_d = pick_idx;
                    // Fresh transaction: a burst that ends before any acked
                    // beat must not inherit the previous write flag.
                    wr_flag_d    = 1'b0;
                    state_d      = REQ;
                end
            end

            REQ: begin
                bus_req    = own_req;
                bus_reqcyc = own_reqcyc;
                bus_reqtag = own_reqtag;
                for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                    cl_reqack[i] = owner_oh[i] & bus_reqack;
                end
                if (own_reqcyc && bus_reqack) begin
                    wr_flag_d = own_reqtag[WRITE_TAG_BIT];
                end
                if (!own_reqcyc) begin
                    if (wr_flag_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = '0;
                        state_d    = RESP;
                    end
                end
            end

            RESP: begin
                bus_respack = own_respack;
                for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                    if (owner_oh[i]) begin
                        cl_resp[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = bus_resp;
                        cl_respcyc[i]                               = bus_respcyc;
                        cl_resptag[i*BUS_TAG_WIDTH +: BUS_TAG_WIDTH] = bus_resptag;
                    end
                end
                if (bus_respcyc && own_respack) begin
                    if (beat_cnt_q == CNT_W'(RESP_BEATS - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= OW'(NUM_CLIENTS - 1);
            beat_cnt_q   <= '0;
            wr_flag_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_flag_q    <= wr_flag_d;
        end
    end

    assign owner         = owner_q;
    assign busy          = (state_q != IDLE);
    assign spurious_resp = bus_respcyc && (state_q != RESP);

endmodule
